// File: rtl/cmd_tx_pkg.sv
// rtl/cmd_tx_pkg.sv - shared state encoding and frame constants for the UART command transmitter
package cmd_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - single-byte 8N1 UART transmitter with level done flag
module uart_tx
  import cmd_tx_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CNT_W-1:0]      baud_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic                  sending;

  // Idle level is forced here rather than by the shift register contents,
  // so a reset-zeroed shifter still leaves the line high.
  assign TX = sending ? shift[0] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      sending  <= 1'b0;
      tx_done  <= 1'b0;
    end else if (trmt) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= {1'b1, tx_data, 1'b0};
      sending  <= 1'b1;
      tx_done  <= 1'b0;
    end else if (sending) begin
      if (baud_cnt == CNT_W'(BAUD_DIV - 1)) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
          sending <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shift   <= {1'b1, shift[FRAME_BITS-1:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// rtl/uart_cmd_tx.sv - sends a 16-bit command as two UART bytes, high byte first
module uart_cmd_tx
  import cmd_tx_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent
);

  state_t      state;
  state_t      next_state;
  logic [15:0] hold;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      cmd_sent <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && snd_cmd) begin
        hold     <= cmd;
        cmd_sent <= 1'b0;
      end else if (state == LOW && tx_done) begin
        cmd_sent <= 1'b1;
      end
    end
  end

  // The high byte comes straight from cmd so the first start bit leaves on the accept edge.
  always_comb begin
    next_state = state;
    trmt       = 1'b0;
    tx_data    = hold[7:0];
    case (state)
      IDLE: begin
        tx_data = cmd[15:8];
        if (snd_cmd) begin
          trmt       = 1'b1;
          next_state = HIGH;
        end
      end
      HIGH: begin
        if (tx_done) begin
          trmt       = 1'b1;
          next_state = LOW;
        end
      end
      LOW: begin
        if (tx_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done)
  );

endmodule

// File: doc/uart_cmd_tx.md
UART_CMD_TX -- requirements
Module: uart_cmd_tx

Interface
REQ-001 Parameter: BAUD_DIV, default 434, clocks per UART bit (50 MHz / 115200).
REQ-002 Port: clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: cmd  input  16  command word to send; sampled only when accepted.
REQ-005 Port: snd_cmd  input  1  request to send cmd; honoured only in IDLE.
REQ-006 Port: TX  output  1  serial line; idles high.
REQ-007 Port: busy  output  1  high whenever state is not IDLE.
REQ-008 Port: cmd_sent  output  1  set-reset flag; high once both bytes are fully on the line.

Function
REQ-009 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly BAUD_DIV clocks.
REQ-010 Byte order SHALL be high byte cmd[15:8] first, then low byte cmd[7:0].
REQ-011 FSM states SHALL be IDLE, HIGH, LOW.
REQ-012 IDLE to HIGH on snd_cmd=1: latch cmd into a 16-bit holding register, issue trmt with the high byte, and clear cmd_sent at the same edge.
REQ-013 With snd_cmd sampled at edge k, TX SHALL go low after edge k, and the byte-1 stop bit SHALL end at edge k+10*BAUD_DIV.
REQ-014 HIGH to LOW on the uart_tx done flag: issue trmt with the latched low byte; exactly one idle-high clock separates the byte-1 stop bit from the byte-2 start bit.
REQ-015 LOW to IDLE on the uart_tx done flag: set cmd_sent at the same edge.
REQ-016 cmd_sent SHALL stay high until the next accepted snd_cmd or reset.
REQ-017 snd_cmd in HIGH or LOW SHALL be ignored: no re-latch, no frame corruption, no queueing.
REQ-018 Changes on cmd after acceptance SHALL NOT affect transmitted bytes.
REQ-019 snd_cmd held high continuously SHALL start a new transfer on the first cycle back in IDLE; back-to-back transfers are legal.
REQ-020 The baud counter SHALL wrap at BAUD_DIV-1; the bit counter SHALL count 0..9 and then stop; no free-running wrap while idle.

Reset
REQ-021 rst=1 SHALL force, asynchronously and regardless of frame position, the state to IDLE, TX=1, busy=0, cmd_sent=0, the uart_tx done flag to 0, and all counters and shift and holding registers to 0.
REQ-022 After rst deasserts, the first snd_cmd SHALL produce a complete, correct two-byte transfer; no partial frame from before reset resumes.

Structure
REQ-023 Shared package cmd_tx_pkg SHALL hold the state enum (IDLE/HIGH/LOW) and frame constants (DATA_BITS=8, FRAME_BITS=10).
REQ-024 One sub-module uart_tx SHALL be instantiated, providing:
  - ports clk, rst, trmt, tx_data[7:0], TX, tx_done;
  - baud counter, bit counter and 10-bit shift register;
  - tx_done as a level flag, set at the end of the stop bit and cleared by trmt.
REQ-025 The whole block SHALL be 120-400 lines of RTL including uart_tx.

Verification (BAUD_DIV=4)
REQ-026 After reset, pulse snd_cmd with cmd=16'hA55A at edge k:
  - TX frames 0xA5 then 0x5A, each bit 4 clocks;
  - one idle cycle between the two frames;
  - cmd_sent rises at edge k+82;
  - busy falls at the same edge.
REQ-027 Change cmd to 16'hFFFF and pulse snd_cmd 10 cycles after sending 16'h1234: the line still carries 0x12, 0x34, and no third frame appears.
REQ-028 Assert rst in the middle of byte 2 of 16'h00FF: TX=1 and cmd_sent=0 immediately; after release, send 16'h8001 and receive exactly 0x80, 0x01.
REQ-029 Hold snd_cmd high for 200 cycles with cmd=16'h0F0F: two complete transfers, each beginning on the cycle after the previous one returns to IDLE.
REQ-030 Apply rst with snd_cmd idle: TX stays 1 for 100 cycles and busy stays 0.
REQ-031 The bench SHALL check each frame with a UART RX reference model that samples mid-bit, and SHALL flag any framing error (stop bit not equal to 1).
